shift_exec_seq: RTL and testbench

- Sequential shift execution unit that sits directly upstream of the writeback path and owns the shift operations for the ALU.
- Accepts one request per transaction over a valid/ready handshake: op, A, B.
- Performs a logical-left, logical-right or arithmetic-right shift of A by B iteratively, up to STEP bit positions per cycle.
- Holds the 32-bit result on a valid/ready output until it is consumed.

---
 rtl/shift_exec_seq_if.sv | 30 +++
 rtl/shift_exec_seq.sv | 113 +++++++++++
 tb/tb_shift_exec_seq.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/shift_exec_seq_if.sv
// +---------------------------------------------------------------------------+
// | Module  : shift_exec_seq_if                                               |
// | Brief   : Request/result handshake bundle for the shift execution unit.   |
// | Rev     : 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

interface shift_exec_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        busy;

    modport master (
        output in_valid, op, A, B, out_ready,
        input  in_ready, out_valid, out, busy
    );

    modport slave (
        input  in_valid, op, A, B, out_ready,
        output in_ready, out_valid, out, busy
    );
endinterface

`default_nettype wire

// File: rtl/shift_exec_seq.sv
// +---------------------------------------------------------------------------+
// | Module  : shift_exec_seq                                                  |
// | Brief   : Iterative sll/srl/sra unit, up to STEP bits per cycle.          |
// |           SHIFT_EXEC_ROTATE_EN enables op 11 = rotate right.              |
// | Rev     : 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module shift_exec_seq #(
    parameter int STEP = 4
) (
    input  wire              clk,
    input  wire              rst_n,
    shift_exec_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [5:0] c_step = 6'(STEP);

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] work_q, work_d;
    logic [5:0]  rem_q, rem_d;
    logic [31:0] out_q, out_d;

    logic [5:0]  w_k;
    logic [31:0] w_shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            work_q  <= '0;
            rem_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        w_k = (rem_q < c_step) ? rem_q : c_step;
        case (op_q)
            2'b00:   w_shifted = work_q << w_k;
            2'b01:   w_shifted = work_q >> w_k;
            2'b10:   w_shifted = $unsigned($signed(work_q) >>> w_k);
`ifdef SHIFT_EXEC_ROTATE_EN
            // A 32-bit shift by 32 yields zero, so k=0 degenerates cleanly.
            default: w_shifted = (work_q >> w_k) | (work_q << (6'd32 - w_k));
`else
            default: w_shifted = work_q;
`endif
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        work_d  = work_q;
        rem_d   = rem_q;
        out_d   = out_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    op_d    = bus.op;
                    work_d  = bus.A;
                    // Saturate: any amount >= 32 behaves as exactly 32.
                    rem_d   = (|bus.B[31:5]) ? 6'd32 : {1'b0, bus.B[4:0]};
                    if (bus.op == 2'b11) begin
`ifdef SHIFT_EXEC_ROTATE_EN
                        rem_d = {1'b0, bus.B[4:0]};
`else
                        rem_d = 6'd0;
`endif
                    end
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                work_d = w_shifted;
                rem_d  = rem_q - w_k;
                if (rem_d == 6'd0) begin
                    out_d   = w_shifted;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q == S_SHIFT) || (state_q == S_DONE);
    assign bus.out       = out_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_exec_seq.sv
// +---------------------------------------------------------------------------+
// | Module  : tb_shift_exec_seq                                               |
// | Brief   : Directed self-checking bench for shift_exec_seq (STEP=4).       |
// | Rev     : 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_shift_exec_seq;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    shift_exec_seq_if bus();

    shift_exec_seq #(.STEP(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drives one request, measures latency, then optionally backpressures.
    task automatic run_vec(input string tag, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                           input int hold, input bit pre_ready, input bit scramble);
        int edges;
        @(negedge clk);
        check({tag, ".in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid  = 1'b1;
        bus.op        = o;
        bus.A         = a;
        bus.B         = b;
        bus.out_ready = pre_ready;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (scramble) begin
            bus.A  = $urandom;
            bus.B  = $urandom;
            bus.op = 2'($urandom_range(0, 3));
        end
        check({tag, ".busy"}, {31'd0, bus.busy}, 32'd1);
        edges = 0;
        while (!bus.out_valid && edges < 50) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check({tag, ".lat"}, edges, exp_lat);
        check({tag, ".out"}, bus.out, exp);
        check({tag, ".rdy_done"}, {31'd0, bus.in_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.A        = $urandom;
            bus.B        = $urandom;
            @(posedge clk);
            @(negedge clk);
            check({tag, ".hold_out"}, bus.out, exp);
            check({tag, ".hold_vld"}, {31'd0, bus.out_valid}, 32'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, ".vld_clr"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, ".rdy_back"}, {31'd0, bus.in_ready}, 32'd1);
        check({tag, ".out_keep"}, bus.out, exp);
    endtask

    initial begin
        n_total       = 0;
        n_bad         = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 2'b00;
        bus.A         = '0;
        bus.B         = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.out",      bus.out, 32'd0);
        check("rst.out_vld",  {31'd0, bus.out_valid}, 32'd0);
        check("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst.busy",     {31'd0, bus.busy}, 32'd0);
        rst_n = 1'b1;

        run_vec("sll5",     2'b00, 32'h0000_0001, 32'd5,  32'h0000_0020, 2, 0, 0, 0);
        run_vec("sra40",    2'b10, 32'h8000_0000, 32'd40, 32'hFFFF_FFFF, 8, 0, 0, 0);
        run_vec("srl40",    2'b01, 32'h8000_0000, 32'd40, 32'h0000_0000, 8, 0, 0, 0);
        run_vec("srl0",     2'b01, 32'hDEAD_BEEF, 32'd0,  32'hDEAD_BEEF, 1, 5, 0, 0);
        run_vec("stable",   2'b01, 32'h1234_5678, 32'd8,  32'h0012_3456, 2, 0, 0, 1);
`ifdef SHIFT_EXEC_ROTATE_EN
        run_vec("op11",     2'b11, 32'h0000_00F1, 32'd4,  32'h1000_000F, 1, 0, 0, 0);
`else
        run_vec("op11",     2'b11, 32'h0000_00F1, 32'd4,  32'h0000_00F1, 1, 0, 0, 0);
`endif
        run_vec("sra4",     2'b10, 32'hF000_0000, 32'd4,  32'hFF00_0000, 1, 0, 1, 0);
        run_vec("sllmax",   2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 8, 0, 0, 0);
        run_vec("sra31p",   2'b10, 32'h7FFF_FFFF, 32'd31, 32'h0000_0000, 8, 0, 0, 0);
        run_vec("srl31",    2'b01, 32'h8000_0000, 32'd31, 32'h0000_0001, 8, 0, 0, 0);
        run_vec("sll7",     2'b00, 32'h0000_00AB, 32'd7,  32'h0000_5580, 2, 0, 1, 0);
        run_vec("srl3",     2'b01, 32'h0000_0080, 32'd3,  32'h0000_0010, 1, 0, 0, 0);

        // Reset in the third SHIFT cycle of a long sll.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = 2'b00;
        bus.A        = 32'h0000_0001;
        bus.B        = 32'd31;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mrst.busy_pre", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mrst.out",      bus.out, 32'd0);
        check("mrst.out_vld",  {31'd0, bus.out_valid}, 32'd0);
        check("mrst.in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("mrst.busy",     {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("post_rst", 2'b00, 32'd3, 32'd1, 32'd6, 1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
